// File: rtl/vid_pkg.sv
// Register map, control/status bit positions and FSM encoding of the rectangle-fill engine.
// Shared with the VideoDriver software headers, so encodings here are part of the ABI.
package vid_pkg;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPos    = 2'd1;
  localparam logic [1:0] RegSize   = 2'd2;
  localparam logic [1:0] RegColour = 2'd3;

  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlClearBit = 1;
  localparam int unsigned StatBusyBit  = 0;
  localparam int unsigned StatDoneBit  = 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StRow   = 3'd2,
    StWrite = 3'd3,
    StFin   = 3'd4
  } vid_state_e;

  // Exclusive end coordinate, clipped to the framebuffer edge; one bit wider than the fields.
  function automatic logic [7:0] clip_end(logic [6:0] start, logic [6:0] len, int unsigned limit);
    logic [7:0] sum;
    sum = {1'b0, start} + {1'b0, len};
    return (32'(sum) > limit) ? 8'(limit) : sum;
  endfunction

endpackage

// File: rtl/vid_span_mask.sv
// Maps a pixel index and exclusive row-end index to the word holding it, the lanes of that
// word that fall inside the span (lane 0 = lowest pixel) and how many pixels are covered.
module vid_span_mask
  import vid_pkg::*;
#(
  parameter int unsigned PixW = 14
) (
  input  logic [PixW-1:0] pix_i,
  input  logic [PixW-1:0] pix_end_i,
  output logic [PixW-3:0] word_off_o,
  output logic [3:0]      byte_en_o,
  output logic [2:0]      pix_count_o
);

  assign word_off_o = pix_i[PixW-1:2];

  always_comb begin
    logic [PixW-1:0] lane_pix;
    byte_en_o   = '0;
    pix_count_o = '0;
    lane_pix    = '0;
    for (int n = 0; n < 4; n++) begin
      lane_pix     = {pix_i[PixW-1:2], n[1:0]};
      byte_en_o[n] = (lane_pix >= pix_i) && (lane_pix < pix_end_i);
      pix_count_o  = pix_count_o + 3'(byte_en_o[n]);
    end
  end

endmodule

// File: rtl/vid_rect_fill.sv
// Rectangle-fill engine: a slave register file starts a clipped solid fill of an 8-bit
// framebuffer, written one 32-bit word per transfer over the master port.
module vid_rect_fill
  import vid_pkg::*;
#(
  parameter int unsigned FB_W          = 80,
  parameter int unsigned FB_H          = 60,
  parameter int unsigned VRAM_BASE     = 0,
  parameter int unsigned ADDR_SEL_BITS = 0
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic                      i_AV_SlaveSel,
  input  logic [29-ADDR_SEL_BITS:0] i_AV_RegAddr,
  input  logic [3:0]                i_AV_ByteEn,
  input  logic                      i_AV_Read,
  input  logic                      i_AV_Write,
  output logic [31:0]               o_AV_ReadData,
  input  logic [31:0]               i_AV_WriteData,
  output logic                      o_AV_WaitRequest,
  output logic [29:0]               o_AVM_Address,
  output logic                      o_AVM_Write,
  output logic [3:0]                o_AVM_ByteEn,
  output logic [31:0]               o_AVM_WriteData,
  input  logic                      i_AVM_WaitRequest,
  output logic                      o_Irq
);

  localparam int unsigned PixW = $clog2(FB_W * FB_H) + 1;

  vid_state_e      state_q;
  logic [6:0]      pos_x_q, pos_y_q, size_w_q, size_h_q;
  logic [7:0]      colour_q;
  logic            done_q;
  logic [6:0]      cur_y_q;
  logic [7:0]      xe_q, ye_q;
  logic [PixW-1:0] row_base_q, row_end_q, p_q;

  logic            busy, wr_en, rd_en, ctrl_wr, start_req, clear_req, empty_rect, more_rows;
  logic [1:0]      reg_sel;
  logic [7:0]      xe_c, ye_c;
  logic [PixW-1:0] row_pix_c, row_end_c, span_pix, span_end;
  logic [PixW-3:0] span_word;
  logic [3:0]      span_be;
  logic [2:0]      span_count;
  logic            unused_bits;

  assign o_AV_WaitRequest = 1'b0;
  assign o_Irq            = done_q;
  assign busy             = (state_q != StIdle);

  assign reg_sel   = i_AV_RegAddr[1:0];
  assign wr_en     = i_AV_SlaveSel && i_AV_Write;
  assign rd_en     = i_AV_SlaveSel && i_AV_Read;
  assign ctrl_wr   = wr_en && (reg_sel == RegCtrl) && i_AV_ByteEn[0];
  assign start_req = ctrl_wr && i_AV_WriteData[CtrlStartBit];
  assign clear_req = ctrl_wr && i_AV_WriteData[CtrlClearBit];

  assign xe_c       = clip_end(pos_x_q, size_w_q, FB_W);
  assign ye_c       = clip_end(pos_y_q, size_h_q, FB_H);
  assign empty_rect = (size_w_q == '0) || (size_h_q == '0) ||
                      (32'(pos_x_q) >= FB_W) || (32'(pos_y_q) >= FB_H);
  assign more_rows  = ({1'b0, cur_y_q} + 8'd1) < ye_q;

  assign row_pix_c = row_base_q + PixW'(pos_x_q);
  assign row_end_c = row_base_q + PixW'(xe_q);
  assign span_pix  = (state_q == StRow) ? row_pix_c : p_q;
  assign span_end  = (state_q == StRow) ? row_end_c : row_end_q;

  assign unused_bits = ^{i_AV_RegAddr[29-ADDR_SEL_BITS:2], i_AV_WriteData[31:23],
                         i_AV_WriteData[15:8], i_AV_ByteEn[3], i_AV_ByteEn[1]};

  vid_span_mask #(
    .PixW(PixW)
  ) u_span (
    .pix_i      (span_pix),
    .pix_end_i  (span_end),
    .word_off_o (span_word),
    .byte_en_o  (span_be),
    .pix_count_o(span_count)
  );

  // Config registers are frozen while busy, so they double as the latched fill parameters.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q         <= StIdle;
      pos_x_q         <= '0;
      pos_y_q         <= '0;
      size_w_q        <= '0;
      size_h_q        <= '0;
      colour_q        <= '0;
      done_q          <= 1'b0;
      cur_y_q         <= '0;
      xe_q            <= '0;
      ye_q            <= '0;
      row_base_q      <= '0;
      row_end_q       <= '0;
      p_q             <= '0;
      o_AV_ReadData   <= '0;
      o_AVM_Address   <= '0;
      o_AVM_Write     <= 1'b0;
      o_AVM_ByteEn    <= '0;
      o_AVM_WriteData <= '0;
    end else begin
      if (wr_en && !busy) begin
        unique case (reg_sel)
          RegPos: begin
            if (i_AV_ByteEn[0]) pos_x_q <= i_AV_WriteData[6:0];
            if (i_AV_ByteEn[2]) pos_y_q <= i_AV_WriteData[22:16];
          end
          RegSize: begin
            if (i_AV_ByteEn[0]) size_w_q <= i_AV_WriteData[6:0];
            if (i_AV_ByteEn[2]) size_h_q <= i_AV_WriteData[22:16];
          end
          RegColour: if (i_AV_ByteEn[0]) colour_q <= i_AV_WriteData[7:0];
          default: ;
        endcase
      end

      o_AV_ReadData <= '0;
      if (rd_en) begin
        unique case (reg_sel)
          RegCtrl:   o_AV_ReadData <= {30'b0, done_q, busy};
          RegPos:    o_AV_ReadData <= {9'b0, pos_y_q, 9'b0, pos_x_q};
          RegSize:   o_AV_ReadData <= {9'b0, size_h_q, 9'b0, size_w_q};
          RegColour: o_AV_ReadData <= {24'b0, colour_q};
          default:   o_AV_ReadData <= '0;
        endcase
      end

      if (clear_req) done_q <= 1'b0;

      unique case (state_q)
        StIdle: if (start_req) state_q <= StSetup;
        StSetup: begin
          if (empty_rect) begin
            state_q <= StFin;
          end else begin
            row_base_q <= PixW'(pos_y_q) * PixW'(FB_W);
            cur_y_q    <= pos_y_q;
            xe_q       <= xe_c;
            ye_q       <= ye_c;
            state_q    <= StRow;
          end
        end
        StRow: begin
          o_AVM_Write     <= 1'b1;
          o_AVM_Address   <= 30'(VRAM_BASE) + 30'(span_word);
          o_AVM_ByteEn    <= span_be;
          o_AVM_WriteData <= {4{colour_q}};
          p_q             <= row_pix_c + PixW'(span_count);
          row_end_q       <= row_end_c;
          state_q         <= StWrite;
        end
        StWrite: begin
          if (!i_AVM_WaitRequest) begin
            if (p_q < row_end_q) begin
              o_AVM_Address <= 30'(VRAM_BASE) + 30'(span_word);
              o_AVM_ByteEn  <= span_be;
              p_q           <= p_q + PixW'(span_count);
            end else begin
              o_AVM_Write  <= 1'b0;
              o_AVM_ByteEn <= '0;
              if (more_rows) begin
                cur_y_q    <= cur_y_q + 7'd1;
                row_base_q <= row_base_q + PixW'(FB_W);
                state_q    <= StRow;
              end else begin
                state_q <= StFin;
              end
            end
          end
        end
        StFin: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vid_rect_fill.sv
// Randomised bench for vid_rect_fill: a pixel-level model of each rectangle predicts the
// master-port word writes, and one monitor process checks every completed transfer.
module tb_vid_rect_fill;

  localparam int FbW = 80;
  localparam int FbH = 60;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_AV_SlaveSel = 1'b0;
  logic [29:0] i_AV_RegAddr = '0;
  logic [3:0]  i_AV_ByteEn = '0;
  logic        i_AV_Read = 1'b0;
  logic        i_AV_Write = 1'b0;
  logic [31:0] o_AV_ReadData;
  logic [31:0] i_AV_WriteData = '0;
  logic        o_AV_WaitRequest;
  logic [29:0] o_AVM_Address;
  logic        o_AVM_Write;
  logic [3:0]  o_AVM_ByteEn;
  logic [31:0] o_AVM_WriteData;
  logic        i_AVM_WaitRequest = 1'b0;
  logic        o_Irq;

  vid_rect_fill #(
    .FB_W(FbW), .FB_H(FbH), .VRAM_BASE(0), .ADDR_SEL_BITS(0)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_AV_SlaveSel(i_AV_SlaveSel), .i_AV_RegAddr(i_AV_RegAddr),
    .i_AV_ByteEn(i_AV_ByteEn), .i_AV_Read(i_AV_Read), .i_AV_Write(i_AV_Write),
    .o_AV_ReadData(o_AV_ReadData), .i_AV_WriteData(i_AV_WriteData),
    .o_AV_WaitRequest(o_AV_WaitRequest), .o_AVM_Address(o_AVM_Address),
    .o_AVM_Write(o_AVM_Write), .o_AVM_ByteEn(o_AVM_ByteEn), .o_AVM_WriteData(o_AVM_WriteData),
    .i_AVM_WaitRequest(i_AVM_WaitRequest), .o_Irq(o_Irq)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         act_q[$];
  logic [31:0] exp_data = '0;
  int          checks = 0;
  int          failures = 0;
  int          stall_mode = 0;  // 0 none, 1 random, 2 first stall_left cycles, 3 hold after hold_at
  int          stall_left = 0;
  int          hold_at = 0;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          first_cyc = -1;
  int          last_cyc = -1;
  int          write_high = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(negedge i_Clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    tick;
    i_AV_SlaveSel = 1'b1; i_AV_Write = 1'b1; i_AV_RegAddr = {28'b0, a};
    i_AV_WriteData = d; i_AV_ByteEn = 4'hf;
    tick;
    i_AV_SlaveSel = 1'b0; i_AV_Write = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    tick;
    i_AV_SlaveSel = 1'b1; i_AV_Read = 1'b1; i_AV_RegAddr = {28'b0, a};
    tick;
    d = o_AV_ReadData;
    i_AV_SlaveSel = 1'b0; i_AV_Read = 1'b0;
  endtask

  // Pixel-by-pixel walk of the clipped rectangle, merged into word writes in order.
  task automatic build_model(input int x, input int y, input int w, input int h,
                             input logic [7:0] c);
    int  xe, ye, n, pix;
    wr_t wv;
    exp_q.delete();
    exp_data = {4{c}};
    xe = (x + w < FbW) ? x + w : FbW;
    ye = (y + h < FbH) ? y + h : FbH;
    for (int yy = y; yy < ye; yy++) begin
      for (int xx = x; xx < xe; xx++) begin
        pix = yy * FbW + xx;
        n = exp_q.size();
        if (n > 0 && exp_q[n-1].addr == 30'(pix / 4)) begin
          wv = exp_q[n-1];
          wv.be[pix % 4] = 1'b1;
          exp_q[n-1] = wv;
        end else begin
          wv.addr = 30'(pix / 4);
          wv.be = 4'b0;
          wv.be[pix % 4] = 1'b1;
          exp_q.push_back(wv);
        end
      end
    end
  endtask

  task automatic start_fill(input int x, input int y, input int w, input int h,
                            input logic [7:0] c, input logic [31:0] ctrl);
    build_model(x, y, w, h, c);
    act_q.delete();
    write_high = 0;
    first_cyc = -1;
    reg_write(2'd1, {9'b0, 7'(y), 9'b0, 7'(x)});
    reg_write(2'd2, {9'b0, 7'(h), 9'b0, 7'(w)});
    reg_write(2'd3, {24'b0, c});
    reg_write(2'd0, ctrl);
  endtask

  task automatic finish_fill(output int n);
    logic [31:0] d;
    n = 0;
    while (!o_Irq && n < 20000) begin
      tick;
      n++;
    end
    chk("done_irq", {31'b0, o_Irq}, 32'd1);
    tick;
    chk("model_drained", exp_q.size(), 32'd0);
    reg_read(2'd0, d);
    chk("stat_done_idle", d, 32'd2);
    reg_write(2'd0, 32'd2);
    chk("irq_cleared", {31'b0, o_Irq}, 32'd0);
  endtask

  // Monitor: picks WaitRequest for the coming edge, then checks what that edge will do.
  initial begin
    logic        prev_stall;
    logic [29:0] prev_addr;
    logic [3:0]  prev_be;
    logic [31:0] prev_data;
    wr_t         e, w;
    prev_stall = 1'b0; prev_addr = '0; prev_be = '0; prev_data = '0;
    forever begin
      @(negedge i_Clk);
      cyc++;
      case (stall_mode)
        1: i_AVM_WaitRequest = ($urandom_range(0, 3) == 0);
        2: begin
          if (o_AVM_Write && stall_left > 0) begin
            i_AVM_WaitRequest = 1'b1;
            stall_left--;
          end else begin
            i_AVM_WaitRequest = 1'b0;
          end
        end
        3: i_AVM_WaitRequest = (act_q.size() >= hold_at);
        default: i_AVM_WaitRequest = 1'b0;
      endcase
      if (mon_en) begin
        if (prev_stall) begin
          chk("stall_write_held", {31'b0, o_AVM_Write}, 32'd1);
          chk("stall_addr_held", {2'b0, o_AVM_Address}, {2'b0, prev_addr});
          chk("stall_be_held", {28'b0, o_AVM_ByteEn}, {28'b0, prev_be});
          chk("stall_data_held", o_AVM_WriteData, prev_data);
        end
        if (o_AVM_Write) write_high++;
        if (o_AVM_Write && !i_AVM_WaitRequest) begin
          w.addr = o_AVM_Address;
          w.be   = o_AVM_ByteEn;
          act_q.push_back(w);
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %0h be %b, expected no write",
                     o_AVM_Address, o_AVM_ByteEn);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {2'b0, o_AVM_Address}, {2'b0, e.addr});
            chk("wr_be", {28'b0, o_AVM_ByteEn}, {28'b0, e.be});
            chk("wr_data", o_AVM_WriteData, exp_data);
          end
        end
      end
      prev_stall = mon_en && o_AVM_Write && i_AVM_WaitRequest;
      prev_addr  = o_AVM_Address;
      prev_be    = o_AVM_ByteEn;
      prev_data  = o_AVM_WriteData;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n, span, rx, ry, rw, rh;
    repeat (3) tick;
    i_Rst = 1'b0;
    tick;

    // Reset state.
    chk("rst_avm_write", {31'b0, o_AVM_Write}, 32'd0);
    chk("rst_avm_be", {28'b0, o_AVM_ByteEn}, 32'd0);
    chk("rst_avm_addr", {2'b0, o_AVM_Address}, 32'd0);
    chk("rst_avm_data", o_AVM_WriteData, 32'd0);
    chk("rst_readdata", o_AV_ReadData, 32'd0);
    chk("rst_irq", {31'b0, o_Irq}, 32'd0);
    chk("waitrequest_tied", {31'b0, o_AV_WaitRequest}, 32'd0);
    reg_read(2'd0, d);
    chk("rst_stat", d, 32'd0);
    mon_en = 1'b1;

    // Small two-word span.
    start_fill(2, 1, 5, 1, 8'hE0, 32'd1);
    finish_fill(n);
    chk("t1_count", act_q.size(), 32'd2);
    if (act_q.size() == 2) begin
      chk("t1_addr0", {2'b0, act_q[0].addr}, 32'd20);
      chk("t1_be0", {28'b0, act_q[0].be}, 32'b1100);
      chk("t1_addr1", {2'b0, act_q[1].addr}, 32'd21);
      chk("t1_be1", {28'b0, act_q[1].be}, 32'b0111);
    end

    // Full screen with no stalls: throughput.
    start_fill(0, 0, 80, 60, 8'h1C, 32'd1);
    finish_fill(n);
    chk("t2_count", act_q.size(), 32'd1200);
    span = last_cyc - first_cyc + 1;
    chk("t2_span_le_1263", {31'b0, span <= 1263}, 32'd1);
    chk("t2_span_ge_1200", {31'b0, span >= 1200}, 32'd1);
    if (act_q.size() == 1200) begin
      chk("t2_first_addr", {2'b0, act_q[0].addr}, 32'd0);
      chk("t2_last_addr", {2'b0, act_q[1199].addr}, 32'd1199);
      chk("t2_last_be", {28'b0, act_q[1199].be}, 32'hf);
    end

    // Bottom-right corner, clipped in both directions.
    start_fill(78, 59, 10, 5, 8'h03, 32'd1);
    finish_fill(n);
    chk("t3_count", act_q.size(), 32'd1);
    if (act_q.size() == 1) begin
      chk("t3_addr", {2'b0, act_q[0].addr}, 32'd1199);
      chk("t3_be", {28'b0, act_q[0].be}, 32'b1100);
    end

    // Three-cycle stall on the first write.
    stall_mode = 2;
    stall_left = 3;
    start_fill(2, 1, 5, 1, 8'h5A, 32'd1);
    finish_fill(n);
    chk("t4_count", act_q.size(), 32'd2);
    chk("t4_write_high_cycles", write_high, 32'd5);
    stall_mode = 0;

    // Empty rectangle finishes quickly with no writes.
    start_fill(10, 10, 0, 5, 8'hFF, 32'd1);
    finish_fill(n);
    chk("t5_done_within_3", {31'b0, n <= 3}, 32'd1);
    chk("t5_no_writes", act_q.size(), 32'd0);

    // Start and config writes while busy are ignored.
    start_fill(10, 10, 30, 4, 8'h33, 32'd1);
    n = 0;
    while (act_q.size() < 3 && n < 1000) begin
      tick;
      n++;
    end
    chk("t6_reached_3_writes", {31'b0, act_q.size() >= 3}, 32'd1);
    reg_write(2'd0, 32'd1);
    reg_write(2'd1, {9'b0, 7'd0, 9'b0, 7'd0});
    reg_write(2'd3, 32'h0000_00AA);
    finish_fill(n);
    chk("t6_count", act_q.size(), 32'd32);
    reg_read(2'd1, d);
    chk("t6_pos_kept", d, {9'b0, 7'd10, 9'b0, 7'd10});

    // Clear and start in one write while DONE is still set.
    start_fill(4, 2, 8, 2, 8'h81, 32'd1);
    n = 0;
    while (!o_Irq && n < 1000) begin
      tick;
      n++;
    end
    chk("t7_first_done", {31'b0, o_Irq}, 32'd1);
    build_model(4, 2, 8, 2, 8'h81);
    act_q.delete();
    reg_write(2'd0, 32'd3);
    chk("t7_irq_cleared_on_start", {31'b0, o_Irq}, 32'd0);
    finish_fill(n);
    chk("t7_count", act_q.size(), 32'd4);

    // Random rectangles under random back-pressure.
    stall_mode = 1;
    for (int i = 0; i < 10; i++) begin
      rx = $urandom_range(0, 90);
      ry = $urandom_range(0, 70);
      rw = $urandom_range(0, 40);
      rh = $urandom_range(0, 12);
      start_fill(rx, ry, rw, rh, 8'($urandom), 32'd1);
      finish_fill(n);
    end

    // Reset in the middle of a full-screen fill with a write stalled.
    stall_mode = 3;
    hold_at = 10;
    start_fill(0, 0, 80, 60, 8'hC3, 32'd1);
    n = 0;
    while (act_q.size() < 10 && n < 1000) begin
      tick;
      n++;
    end
    chk("t9_reached_10_writes", act_q.size(), 32'd10);
    tick;
    tick;
    mon_en = 1'b0;
    i_Rst = 1'b1;
    tick;
    i_Rst = 1'b0;
    chk("t9_write_dropped", {31'b0, o_AVM_Write}, 32'd0);
    chk("t9_be_zero", {28'b0, o_AVM_ByteEn}, 32'd0);
    chk("t9_addr_zero", {2'b0, o_AVM_Address}, 32'd0);
    chk("t9_data_zero", o_AVM_WriteData, 32'd0);
    chk("t9_irq_zero", {31'b0, o_Irq}, 32'd0);
    stall_mode = 0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (o_AVM_Write) n++;
    end
    chk("t9_no_further_writes", n, 32'd0);
    reg_read(2'd0, d);
    chk("t9_stat_zero", d, 32'd0);
    reg_read(2'd1, d);
    chk("t9_pos_zero", d, 32'd0);
    reg_read(2'd3, d);
    chk("t9_colour_zero", d, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vid_rect_fill.md
VID_RECT_FILL -- requirements
Module: vid_rect_fill

Interface
REQ-001 SHALL have parameter FB_W, default 80, framebuffer width in pixels (multiple of 4).
REQ-002 SHALL have parameter FB_H, default 60, framebuffer height in pixels.
REQ-003 SHALL have parameter VRAM_BASE, default 0, word address of pixel 0 on the master bus.
REQ-004 SHALL have parameter ADDR_SEL_BITS, default 0, slave address bits consumed by the bus decoder.
REQ-005 SHALL have one clock and a synchronous, active-high reset: i_Clk in 1, clock, all logic on rising edge; i_Rst in 1, reset.
REQ-006 SHALL have the slave port: i_AV_SlaveSel in 1; i_AV_RegAddr in 30-ADDR_SEL_BITS; i_AV_ByteEn in 4; i_AV_Read in 1; i_AV_Write in 1; o_AV_ReadData out 32; i_AV_WriteData in 32; o_AV_WaitRequest out 1, tied 0.
REQ-007 SHALL have the master port: o_AVM_Address out 30, word address; o_AVM_Write out 1; o_AVM_ByteEn out 4; o_AVM_WriteData out 32; i_AVM_WaitRequest in 1.
REQ-008 SHALL have o_Irq out 1, level, high while DONE flag set.

Function
REQ-009 SHALL decode slave registers on RegAddr[1:0]: 0 CTRL/STAT, 1 POS (X [6:0], Y [22:16]), 2 SIZE (W [6:0], H [22:16]), 3 COLOUR [7:0] (RGB332).
REQ-010 SHALL return read data registered one cycle after i_AV_Read; unselected cycles drive 0; STAT read = {30'b0, DONE, BUSY}.
REQ-011 SHALL, on CTRL write bit0=1 while idle, latch POS/SIZE/COLOUR and start a fill; start while BUSY SHALL be ignored.
REQ-012 SHALL ignore writes to POS/SIZE/COLOUR while BUSY; CTRL bit1=1 SHALL clear DONE; clear and start in one write: clear first, then start.
REQ-013 SHALL use FSM IDLE -> SETUP -> ROW -> WRITE -> (WRITE | ROW | FIN) -> IDLE; BUSY=1 in all states except IDLE.
REQ-014 SETUP SHALL clip: XE=min(X+W,FB_W), YE=min(Y+H,FB_H); if W=0, H=0, X>=FB_W or Y>=FB_H, go to FIN with no writes.
REQ-015 ROW SHALL compute pixel index P=Y*FB_W+X for the current row start; WRITE SHALL issue one word per transfer covering pixels P..min(XE-1, next 4-aligned boundary-1).
REQ-016 SHALL drive o_AVM_Address=VRAM_BASE+(P>>2), o_AVM_WriteData={4{COLOUR}}, o_AVM_ByteEn bit n set iff pixel (P&~3)+n in span (lane 0 = lowest pixel).
REQ-017 SHALL hold Address/Write/ByteEn/WriteData stable while i_AVM_WaitRequest=1; a transfer completes on the cycle Write=1 and WaitRequest=0.
REQ-018 SHALL sustain one completed write per cycle when WaitRequest=0, including across row boundaries (ROW costs at most 1 bubble per row).
REQ-019 FIN SHALL set DONE for one entry, then return to IDLE; DONE stays set until cleared or reset.
REQ-020 SHALL keep all arithmetic at widths sufficient for FB_W*FB_H pixels without wrap; X+W and Y+H computed one bit wider than the fields.

Reset
REQ-021 i_Rst SHALL force state IDLE, BUSY=0, DONE=0, o_Irq=0, o_AVM_Write=0, o_AVM_ByteEn=0, o_AVM_Address=0, o_AVM_WriteData=0, o_AV_ReadData=0, all config registers 0.
REQ-022 Reset asserted mid-fill SHALL abort immediately, including a write stalled by WaitRequest; no further writes issued.

Structure
REQ-023 SHALL place register offsets, CTRL bit indices and FSM state encodings in a shared package vid_pkg, reused by VideoDriver software headers.
REQ-024 SHALL be one module with one natural sub-module vid_span_mask (pixel index, XE -> word offset, ByteEn, pixel count).

Verification
REQ-025 X=2,Y=1,W=5,H=1,COLOUR=E0, start -> writes addr 20 ByteEn 1100, addr 21 ByteEn 0111, data E0E0E0E0; DONE=1, o_Irq=1.
REQ-026 X=0,Y=0,W=80,H=60 -> exactly 1200 writes, addresses 0..1199 ascending, all ByteEn 1111, 1200 cycles + at most 63 bubbles with WaitRequest=0.
REQ-027 X=78,Y=59,W=10,H=5 (clipped) -> single write addr 1199 ByteEn 1100, then DONE.
REQ-028 WaitRequest held 3 cycles on first write -> outputs unchanged for those cycles, transfer counted once, total writes unchanged.
REQ-029 W=0 start -> no o_AVM_Write pulses, DONE=1 within 3 cycles; second start while BUSY during a fill -> ignored, write count unchanged.
REQ-030 i_Rst pulsed after 10 writes of full-screen fill -> next cycle o_AVM_Write=0, STAT reads 0, no further writes.
